// File: rtl/vfu_result_wbuffer.sv
// Lane write-back buffer: two FU result FIFOs merged round-robin onto one VRF write port,
// with per-instruction pending flags for the sequencer.
module vfu_result_wbuffer #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NrVInsn   = 8,
  parameter int unsigned IdWidth   = $clog2(NrVInsn)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alu_req_i,
  input  logic [IdWidth-1:0]     alu_id_i,
  input  logic [AddrWidth-1:0]   alu_addr_i,
  input  logic [DataWidth-1:0]   alu_wdata_i,
  input  logic [DataWidth/8-1:0] alu_be_i,
  output logic                   alu_gnt_o,
  input  logic                   mfpu_req_i,
  input  logic [IdWidth-1:0]     mfpu_id_i,
  input  logic [AddrWidth-1:0]   mfpu_addr_i,
  input  logic [DataWidth-1:0]   mfpu_wdata_i,
  input  logic [DataWidth/8-1:0] mfpu_be_i,
  output logic                   mfpu_gnt_o,
  output logic                   vrf_req_o,
  output logic [IdWidth-1:0]     vrf_id_o,
  output logic [AddrWidth-1:0]   vrf_addr_o,
  output logic [DataWidth-1:0]   vrf_wdata_o,
  output logic [DataWidth/8-1:0] vrf_be_o,
  output logic                   vrf_src_o,
  input  logic                   vrf_gnt_i,
  output logic [NrVInsn-1:0]     pending_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned EntWidth = IdWidth + AddrWidth + DataWidth + BeWidth;
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam int unsigned PndWidth = $clog2(2 * Depth + 1);

  // Index 0 is the ALU channel, index 1 the MFPU channel.
  logic [EntWidth-1:0] r_mem  [2][Depth];
  logic [PtrWidth-1:0] r_wptr [2];
  logic [PtrWidth-1:0] r_rptr [2];
  logic [CntWidth-1:0] r_cnt  [2];
  logic                r_rr;
  logic                r_hold;
  logic                r_hold_sel;
  logic [PndWidth-1:0] r_pnd  [NrVInsn];
  logic [NrVInsn-1:0]  r_pending;

  logic [EntWidth-1:0] w_in   [2];
  logic [1:0]          w_ne;
  logic [1:0]          w_full;
  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic                w_sel;
  logic                w_fire;
  logic [EntWidth-1:0] w_head;
  logic [PndWidth-1:0] w_pnd_d [NrVInsn];

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_in[0] = {alu_id_i, alu_addr_i, alu_wdata_i, alu_be_i};
    w_in[1] = {mfpu_id_i, mfpu_addr_i, mfpu_wdata_i, mfpu_be_i};
    for (int c = 0; c < 2; c++) begin
      w_ne[c]   = (r_cnt[c] != '0);
      w_full[c] = (r_cnt[c] == CntWidth'(Depth));
    end
    alu_gnt_o  = alu_req_i & ~w_full[0] & ~rst_i;
    mfpu_gnt_o = mfpu_req_i & ~w_full[1] & ~rst_i;
    w_push     = {mfpu_gnt_o, alu_gnt_o};
    vrf_req_o  = |w_ne;
    // A stalled request keeps its source even if the other FIFO fills meanwhile.
    if (r_hold)       w_sel = r_hold_sel;
    else if (&w_ne)   w_sel = r_rr;
    else              w_sel = w_ne[1];
    w_fire = vrf_req_o & vrf_gnt_i;
    w_pop  = w_fire ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    w_head = vrf_req_o ? r_mem[w_sel][r_rptr[w_sel]] : '0;
    {vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o} = w_head;
    vrf_src_o = vrf_req_o & w_sel;
  end

  always_comb begin
    for (int i = 0; i < NrVInsn; i++) begin
      w_pnd_d[i] = r_pnd[i]
                 + PndWidth'(w_push[0] && (alu_id_i == IdWidth'(i)))
                 + PndWidth'(w_push[1] && (mfpu_id_i == IdWidth'(i)))
                 - PndWidth'(w_fire && (vrf_id_o == IdWidth'(i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < 2; c++) begin
        for (int d = 0; d < Depth; d++) r_mem[c][d] <= '0;
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_rr       <= 1'b0;
      r_hold     <= 1'b0;
      r_hold_sel <= 1'b0;
      for (int i = 0; i < NrVInsn; i++) r_pnd[i] <= '0;
      r_pending  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) begin
          r_mem[c][r_wptr[c]] <= w_in[c];
          r_wptr[c]           <= ptr_inc(r_wptr[c]);
        end
        if (w_pop[c]) r_rptr[c] <= ptr_inc(r_rptr[c]);
        r_cnt[c] <= r_cnt[c] + CntWidth'(w_push[c]) - CntWidth'(w_pop[c]);
      end
      if (w_fire) r_rr <= ~w_sel;
      r_hold     <= vrf_req_o & ~vrf_gnt_i;
      r_hold_sel <= w_sel;
      for (int i = 0; i < NrVInsn; i++) begin
        r_pnd[i]     <= w_pnd_d[i];
        r_pending[i] <= (w_pnd_d[i] != '0);
      end
    end
  end

  assign pending_o = r_pending;

endmodule

// File: tb/tb_vfu_result_wbuffer.sv
// Self-checking bench: queue-based reference model plus directed scenarios and random traffic.
module tb_vfu_result_wbuffer;
  localparam int Depth = 2;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_req = 1'b0, mfpu_req = 1'b0, vrf_gnt = 1'b0;
  logic [2:0]  alu_id = '0, mfpu_id = '0;
  logic [15:0] alu_addr = '0, mfpu_addr = '0;
  logic [63:0] alu_data = '0, mfpu_data = '0;
  logic [7:0]  alu_be = '0, mfpu_be = '0;
  logic        alu_gnt, mfpu_gnt, vrf_req, vrf_src;
  logic [2:0]  vrf_id;
  logic [15:0] vrf_addr;
  logic [63:0] vrf_wdata;
  logic [7:0]  vrf_be;
  logic [7:0]  pending;

  always #5 clk = ~clk;

  vfu_result_wbuffer #(
    .Depth(Depth), .AddrWidth(16), .DataWidth(64), .NrVInsn(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_req_i(alu_req), .alu_id_i(alu_id), .alu_addr_i(alu_addr),
    .alu_wdata_i(alu_data), .alu_be_i(alu_be), .alu_gnt_o(alu_gnt),
    .mfpu_req_i(mfpu_req), .mfpu_id_i(mfpu_id), .mfpu_addr_i(mfpu_addr),
    .mfpu_wdata_i(mfpu_data), .mfpu_be_i(mfpu_be), .mfpu_gnt_o(mfpu_gnt),
    .vrf_req_o(vrf_req), .vrf_id_o(vrf_id), .vrf_addr_o(vrf_addr),
    .vrf_wdata_o(vrf_wdata), .vrf_be_o(vrf_be), .vrf_src_o(vrf_src),
    .vrf_gnt_i(vrf_gnt), .pending_o(pending)
  );

  int   ncmp = 0;
  int   nfail = 0;
  ent_t qa[$];
  ent_t qm[$];
  bit   rr = 0, stall = 0, stall_src = 0;
  bit   e_req, e_src, e_ag, e_mg;
  ent_t e_head;
  logic [7:0] e_pnd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from buffered contents and the arbitration rules.
  task automatic model_eval();
    e_req = (qa.size() != 0) || (qm.size() != 0);
    if (stall)                                 e_src = stall_src;
    else if (qa.size() != 0 && qm.size() != 0) e_src = rr;
    else                                       e_src = (qm.size() != 0);
    e_head = '0;
    if (e_req) e_head = e_src ? qm[0] : qa[0];
    e_ag  = !rst && alu_req && (qa.size() < Depth);
    e_mg  = !rst && mfpu_req && (qm.size() < Depth);
    e_pnd = '0;
    foreach (qa[k]) e_pnd[qa[k].id] = 1'b1;
    foreach (qm[k]) e_pnd[qm[k].id] = 1'b1;
  endtask

  task automatic model_update();
    ent_t e;
    if (rst) begin
      qa.delete(); qm.delete();
      rr = 0; stall = 0; stall_src = 0;
    end else begin
      if (e_req && vrf_gnt) begin
        if (e_src) void'(qm.pop_front());
        else       void'(qa.pop_front());
        rr = !e_src;
      end
      stall     = e_req && !vrf_gnt;
      stall_src = e_src;
      if (e_ag) begin
        e = '{id: alu_id, addr: alu_addr, data: alu_data, be: alu_be};
        qa.push_back(e);
      end
      if (e_mg) begin
        e = '{id: mfpu_id, addr: mfpu_addr, data: mfpu_data, be: mfpu_be};
        qm.push_back(e);
      end
    end
  endtask

  task automatic step();
    #1;
    model_eval();
    chk("vrf_req", vrf_req, e_req);
    chk("alu_gnt", alu_gnt, e_ag);
    chk("mfpu_gnt", mfpu_gnt, e_mg);
    chk("pending", pending, e_pnd);
    if (e_req) begin
      chk("vrf_src", vrf_src, e_src);
      chk("vrf_id", vrf_id, e_head.id);
      chk("vrf_addr", vrf_addr, e_head.addr);
      chk("vrf_wdata", vrf_wdata, e_head.data);
      chk("vrf_be", vrf_be, e_head.be);
    end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_alu(input bit r, input logic [2:0] id, input logic [15:0] a,
                         input logic [63:0] d);
    alu_req = r; alu_id = id; alu_addr = a; alu_data = d; alu_be = 8'hFF;
  endtask

  task automatic set_mfpu(input bit r, input logic [2:0] id, input logic [15:0] a,
                          input logic [63:0] d);
    mfpu_req = r; mfpu_id = id; mfpu_addr = a; mfpu_data = d; mfpu_be = 8'h0F;
  endtask

  task automatic do_reset();
    rst = 1'b1; vrf_gnt = 1'b0;
    set_alu(0, 0, 0, 0); set_mfpu(0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    do_reset();

    // Reset state
    #1;
    chk("rst_req", vrf_req, 0);
    chk("rst_pending", pending, 0);
    chk("rst_id", vrf_id, 0);
    chk("rst_addr", vrf_addr, 0);
    chk("rst_data", vrf_wdata, 0);
    chk("rst_be", vrf_be, 0);
    chk("rst_src", vrf_src, 0);
    chk("rst_alu_gnt", alu_gnt, 0);
    step();

    // Pass-through
    vrf_gnt = 1'b1;
    set_alu(1, 3, 16'h10, 64'hA5);
    step();
    set_alu(0, 0, 0, 0);
    #1;
    chk("pt_req", vrf_req, 1);
    chk("pt_id", vrf_id, 3);
    chk("pt_addr", vrf_addr, 16'h10);
    chk("pt_data", vrf_wdata, 64'hA5);
    chk("pt_src", vrf_src, 0);
    chk("pt_pnd3", pending[3], 1);
    step();
    #1;
    chk("pt_pnd3_clr", pending[3], 0);
    chk("pt_req_clr", vrf_req, 0);
    step();

    // Backpressure / full
    do_reset();
    set_alu(1, 1, 16'h20, 64'h111); #1 chk("bp_gnt0", alu_gnt, 1); step();
    set_alu(1, 1, 16'h21, 64'h222); #1 chk("bp_gnt1", alu_gnt, 1); step();
    set_alu(1, 1, 16'h22, 64'h333); #1 chk("bp_gnt2", alu_gnt, 0); step();
    vrf_gnt = 1'b1;
    set_alu(1, 1, 16'h23, 64'h444);
    #1 chk("bp_full_pop_gnt", alu_gnt, 0); chk("bp_d0", vrf_wdata, 64'h111); step();
    #1 chk("bp_gnt_back", alu_gnt, 1); chk("bp_d1", vrf_wdata, 64'h222); step();
    set_alu(0, 0, 0, 0);
    #1 chk("bp_d2", vrf_wdata, 64'h444); step();
    #1 chk("bp_empty", vrf_req, 0); step();

    // Round robin with a stall first
    do_reset();
    set_alu(1, 0, 16'h30, 64'hA0); set_mfpu(1, 4, 16'h40, 64'hB0); step();
    set_alu(1, 0, 16'h31, 64'hA1); set_mfpu(1, 4, 16'h41, 64'hB1); step();
    set_alu(0, 0, 0, 0); set_mfpu(0, 0, 0, 0);
    step();
    #1 chk("rr_hold_src", vrf_src, 0); chk("rr_hold_data", vrf_wdata, 64'hA0); step();
    vrf_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_src_seq", vrf_src, k % 2);
      step();
    end

    // Same-ID dual push
    do_reset();
    set_alu(1, 5, 16'h50, 64'h5A); set_mfpu(1, 5, 16'h51, 64'h5B); step();
    set_alu(0, 0, 0, 0); set_mfpu(0, 0, 0, 0);
    #1 chk("dual_pnd_a", pending[5], 1); step();
    vrf_gnt = 1'b1;
    #1 chk("dual_pnd_b", pending[5], 1); step();
    #1 chk("dual_pnd_c", pending[5], 1); step();
    #1 chk("dual_pnd_d", pending[5], 0); chk("dual_req", vrf_req, 0); step();

    // Push and pop in the same cycle
    do_reset();
    set_alu(1, 2, 16'h60, 64'h61); step();
    vrf_gnt = 1'b1;
    set_alu(1, 2, 16'h62, 64'h62); step();
    set_alu(0, 0, 0, 0); vrf_gnt = 1'b0;
    #1 chk("pp_req", vrf_req, 1); chk("pp_data", vrf_wdata, 64'h62); chk("pp_pnd2", pending[2], 1);
    step();
    vrf_gnt = 1'b1; step();
    #1 chk("pp_empty", vrf_req, 0); step();

    // Reset mid-operation
    do_reset();
    set_alu(1, 6, 16'h70, 64'h71); set_mfpu(1, 7, 16'h72, 64'h73); step();
    set_mfpu(0, 0, 0, 0);
    set_alu(1, 6, 16'h74, 64'h75); step();
    rst = 1'b1;
    set_alu(1, 1, 16'h76, 64'h77); set_mfpu(1, 1, 16'h78, 64'h79);
    #1 chk("mr_alu_gnt", alu_gnt, 0); chk("mr_mfpu_gnt", mfpu_gnt, 0); step();
    rst = 1'b0;
    set_alu(0, 0, 0, 0); set_mfpu(0, 0, 0, 0);
    #1 chk("mr_req", vrf_req, 0); chk("mr_pending", pending, 0); step();
    #1 chk("mr_not_stored", vrf_req, 0); step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(99) == 0);
      vrf_gnt = $urandom_range(1);
      set_alu($urandom_range(9) < 6, 3'($urandom_range(7)), 16'($urandom),
              {$urandom, $urandom});
      alu_be = 8'($urandom);
      set_mfpu($urandom_range(9) < 6, 3'($urandom_range(7)), 16'($urandom),
               {$urandom, $urandom});
      mfpu_be = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
